// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: N_CH button conditioner (sync, polarity, debounce, press/release pulses).
// Optional auto-repeat when BTN_AUTOREPEAT_EN is defined; release/repeat ports are release_p/repeat_p.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_raw    raw asynchronous button pins [N_CH]
//   level      debounced level, 1 = pressed [N_CH]
//   press      1-cycle pulse on accepted press (and on repeat when enabled) [N_CH]
//   release_p  1-cycle pulse on accepted release [N_CH]
//   repeat_p   1-cycle pulse on auto-repeat only [N_CH]
//   any_press  OR of press, same cycle
// Macro: BTN_AUTOREPEAT_EN enables per-channel hold counters.
module btn_debounce_bank #(
  parameter int N_CH         = 5,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int ACTIVE_LOW   = 0,
  parameter int RPT_W        = 28,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] repeat_p,
  output logic            any_press
);

  if (N_CH < 1 || CNT_W < 1 || DEBOUNCE_CYC < 1 || RPT_W < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("btn_debounce_bank: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [N_CH-1:0] s0_q, s0_d;
  logic [N_CH-1:0] s1_q, s1_d;
  logic [N_CH-1:0] lvl_q, lvl_d;
  logic [N_CH-1:0] prs_q, prs_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic [N_CH-1:0] rpt_q, rpt_d;
  logic            any_q, any_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] acc;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] hold_q [N_CH];
  logic [RPT_W-1:0] hold_d [N_CH];
  // Set after the first repeat: later repeats use the shorter rate.
  logic [N_CH-1:0] rate_q, rate_d;
  logic [RPT_W-1:0] tgt;
`endif

  always_comb begin
    s0_d  = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    s1_d  = s0_q;
    lvl_d = lvl_q;
    prs_d = '0;
    rel_d = '0;
    rpt_d = '0;
    acc   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s1_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          acc[i]   = 1'b1;
          lvl_d[i] = s1_q[i];
          prs_d[i] = s1_q[i];
          rel_d[i] = ~s1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    rate_d = rate_q;
    tgt    = '0;
    for (int i = 0; i < N_CH; i++) begin
      hold_d[i] = '0;
      tgt       = rate_q[i] ? RATE_LAST : DLY_LAST;
      // Any accepted edge restarts the hold; a release never repeats.
      if (!lvl_q[i] || acc[i]) begin
        rate_d[i] = 1'b0;
      end else if (hold_q[i] == tgt) begin
        prs_d[i]  = 1'b1;
        rpt_d[i]  = 1'b1;
        rate_d[i] = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
`endif
    any_d = |prs_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      lvl_q <= '0;
      prs_q <= '0;
      rel_q <= '0;
      rpt_q <= '0;
      any_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
      rpt_q <= rpt_d;
      any_q <= any_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= '0;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      rate_q <= rate_d;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
    end
  end
`endif

  assign level     = lvl_q;
  assign press     = prs_q;
  assign release_p = rel_q;
  assign repeat_p  = rpt_q;
  assign any_press = any_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank: directed + random checks of btn_debounce_bank.
// u0 is active-high, u1 active-low; both N_CH=3, debounce 4, delay 10, rate 3.
module tb_btn_debounce_bank;

  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int RT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] b0, b1;
  logic [2:0] l0, p0, r0, t0;
  logic [2:0] l1, p1, r1, t1;
  logic a0, a1;
  int total = 0;
  int bad = 0;
  int cnt;

  always #5 clk = ~clk;

  btn_debounce_bank #(
    .N_CH(3), .CNT_W(8), .DEBOUNCE_CYC(D), .ACTIVE_LOW(0),
    .RPT_W(8), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(b0),
    .level(l0), .press(p0), .release_p(r0),
    .repeat_p(t0), .any_press(a0)
  );

  btn_debounce_bank #(
    .N_CH(3), .CNT_W(8), .DEBOUNCE_CYC(D), .ACTIVE_LOW(1),
    .RPT_W(8), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(b1),
    .level(l1), .press(p1), .release_p(r1),
    .repeat_p(t1), .any_press(a1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the synchronised value seen at an edge is the pin
  // sampled two edges earlier; a new level needs D consecutive
  // mismatching edges; repeats fall DLY, DLY+RT, ... edges after a press.
  bit md1 [2][3];
  bit md2 [2][3];
  bit mlv [2][3];
  int mstk [2][3];
  int mhld [2][3];
  logic [2:0] e_lvl [2];
  logic [2:0] e_prs [2];
  logic [2:0] e_rel [2];
  logic [2:0] e_rpt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_lvl[i] = '0; e_prs[i] = '0; e_rel[i] = '0; e_rpt[i] = '0;
      for (int c = 0; c < 3; c++) begin
        md1[i][c] = 0; md2[i][c] = 0; mlv[i][c] = 0;
        mstk[i][c] = 0; mhld[i][c] = 0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin : mdl
    bit x;
    bit inp;
    for (int i = 0; i < 2; i++) begin
      e_prs[i] = '0;
      e_rel[i] = '0;
      e_rpt[i] = '0;
      for (int c = 0; c < 3; c++) begin
        if (!rst_n) begin
          md1[i][c] = 0; md2[i][c] = 0; mlv[i][c] = 0;
          mstk[i][c] = 0; mhld[i][c] = 0;
        end else begin
          inp = (i == 0) ? b0[c] : !b1[c];
          x = md2[i][c];
          md2[i][c] = md1[i][c];
          md1[i][c] = inp;
          if (x != mlv[i][c]) mstk[i][c]++;
          else mstk[i][c] = 0;
          if (mstk[i][c] == D) begin
            mlv[i][c] = x;
            mstk[i][c] = 0;
            mhld[i][c] = 0;
            if (x) e_prs[i][c] = 1'b1;
            else e_rel[i][c] = 1'b1;
          end else if (mlv[i][c]) begin
            mhld[i][c]++;
`ifdef BTN_AUTOREPEAT_EN
            if (mhld[i][c] >= DLY && (mhld[i][c] - DLY) % RT == 0) begin
              e_prs[i][c] = 1'b1;
              e_rpt[i][c] = 1'b1;
            end
`endif
          end
        end
        e_lvl[i][c] = mlv[i][c];
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_lvl0", l0, e_lvl[0]);
    chk("cmp_prs0", p0, e_prs[0]);
    chk("cmp_rel0", r0, e_rel[0]);
    chk("cmp_rpt0", t0, e_rpt[0]);
    chk("cmp_any0", a0, |e_prs[0]);
    chk("cmp_lvl1", l1, e_lvl[1]);
    chk("cmp_prs1", p1, e_prs[1]);
    chk("cmp_rel1", r1, e_rel[1]);
    chk("cmp_rpt1", t1, e_rpt[1]);
    chk("cmp_any1", a1, |e_prs[1]);
  end

  initial begin
    rst_n = 1'b0;
    b0 = 3'b111;
    b1 = 3'b000;
    step(3);
    chk("rst_out0", {l0, p0, r0, t0, a0}, 0);
    chk("rst_out1", {l1, p1, r1, t1, a1}, 0);
    rst_n = 1'b1;
    step(5);
    chk("rst_pre_lvl", l0, 3'b000);
    step(1);
    chk("rst_prs0", p0, 3'b111);
    chk("rst_lvl0", l0, 3'b111);
    chk("rst_any0", a0, 1);
    chk("rst_prs1", p1, 3'b111);
    step(1);
    chk("rst_prs_1cyc", p0, 3'b000);
    b0 = 3'b000;
    b1 = 3'b111;
    step(10);

    b0[0] = 1'b1;
    step(5);
    chk("clean_pre", p0[0], 0);
    step(1);
    chk("clean_prs", {p0[0], l0[0], r0[0]}, 3'b110);
    step(14);
    b0[0] = 1'b0;
    step(5);
    chk("clean_rel_pre", r0[0], 0);
    step(1);
    chk("clean_rel", {r0[0], l0[0], p0[0]}, 3'b100);
    step(6);

    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      b0[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(1);
        cnt += int'(p0[1]);
      end
      b0[1] = 1'b0;
      step(1);
      cnt += int'(p0[1]);
    end
    b0[1] = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step(1);
      cnt += int'(p0[1]);
    end
    chk("bounce_cnt", cnt, 1);
    b0[1] = 1'b0;
    step(8);

    chk("alow_idle", l1[2], 0);
    b1[2] = 1'b0;
    step(5);
    chk("alow_pre", p1[2], 0);
    step(1);
    chk("alow_prs", {p1[2], l1[2]}, 2'b11);
    b1[2] = 1'b1;
    step(8);

    b0[1] = 1'b1;
    step(8);
    chk("hold_lvl", l0, 3'b010);
    b0[0] = 1'b1;
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out0", {l0, p0, r0, t0, a0}, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_pre", {p0, l0}, 0);
    step(1);
    chk("post_rst_prs", {p0, l0}, 6'b011011);
    b0 = 3'b000;
    step(10);

    b0[0] = 1'b1;
    step(6);
    chk("ar_prs", {p0[0], t0[0]}, 2'b10);
    step(9);
    chk("ar_gap", {p0[0], t0[0]}, 2'b00);
    step(1);
`ifdef BTN_AUTOREPEAT_EN
    chk("ar_rpt1", {p0[0], t0[0]}, 2'b11);
`else
    chk("ar_rpt1", {p0[0], t0[0]}, 2'b00);
`endif
    step(3);
`ifdef BTN_AUTOREPEAT_EN
    chk("ar_rpt2", {p0[0], t0[0]}, 2'b11);
`else
    chk("ar_rpt2", {p0[0], t0[0]}, 2'b00);
`endif
    step(1);
    chk("ar_gap2", {p0[0], t0[0]}, 2'b00);
    b0[0] = 1'b0;
    step(10);

    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, (n < 2000) ? 3 : 19) == 0) b0[c] = ~b0[c];
        if ($urandom_range(0, (n < 2000) ? 3 : 19) == 0) b1[c] = ~b1[c];
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
